// File: rtl/logic_proc_cmd_driver.sv
// rtl/logic_proc_cmd_driver.sv - command-driven load/execute/check sequencer for the logic processor
module logic_proc_cmd_driver #(
  parameter int WIDTH     = 4,
  parameter int LOAD_HOLD = 2,
  parameter int EXEC_HOLD = 8,
  parameter int GAP       = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [2*WIDTH-1:0] cmd_data,
  input  logic [2:0]         cmd_f,
  input  logic [1:0]         cmd_r,
  output logic [WIDTH-1:0]   Din,
  output logic               LoadA,
  output logic               LoadB,
  output logic               Execute,
  output logic [2:0]         F,
  output logic [1:0]         R,
  input  logic [WIDTH-1:0]   Aval,
  input  logic [WIDTH-1:0]   Bval,
  output logic               busy,
  output logic               chk_fail,
  output logic [7:0]         err_count
);

  localparam int MAX_AB = (EXEC_HOLD > LOAD_HOLD) ? EXEC_HOLD : LOAD_HOLD;
  localparam int MAXH   = (MAX_AB > GAP) ? MAX_AB : GAP;
  localparam int CW     = $clog2(MAXH + 1);

  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_HOLD - 1);
  localparam logic [CW-1:0] EXEC_INIT = CW'(EXEC_HOLD - 1);
  localparam logic [CW-1:0] GAP_INIT  = CW'(GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] data_q, data_d;
  logic [2:0]         f_q, f_d;
  logic [1:0]         r_q, r_d;
  logic [7:0]         err_q, err_d;
  logic               mismatch;

  assign mismatch = (Aval != data_q[2*WIDTH-1:WIDTH]) || (Bval != data_q[WIDTH-1:0]);

  // cnt_q holds remaining cycles minus one in the current timed state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    f_d     = f_q;
    r_d     = r_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          case (cmd_op)
            2'b10: begin
              state_d = S_EXEC;
              cnt_d   = EXEC_INIT;
              f_d     = cmd_f;
              r_d     = cmd_r;
            end
            2'b11: state_d = S_CHECK;
            default: begin
              state_d = S_LOAD;
              cnt_d   = LOAD_INIT;
            end
          endcase
        end
      end
      S_LOAD, S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_INIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      f_q     <= '0;
      r_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      f_q     <= f_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  // F/R only update on an EXEC accept from IDLE, so they are stable while Execute is high
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign LoadA     = (state_q == S_LOAD) && (op_q == 2'b00);
  assign LoadB     = (state_q == S_LOAD) && (op_q == 2'b01);
  assign Execute   = (state_q == S_EXEC);
  assign Din       = (state_q == S_LOAD) ? data_q[WIDTH-1:0] : '0;
  assign F         = f_q;
  assign R         = r_q;
  assign chk_fail  = (state_q == S_CHECK) && mismatch;
  assign err_count = err_q;

endmodule

// File: tb/tb_logic_proc_cmd_driver.sv
// tb/tb_logic_proc_cmd_driver.sv - directed self-checking bench for logic_proc_cmd_driver
module tb_logic_proc_cmd_driver;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic [2:0] cmd_f = '0;
  logic [1:0] cmd_r = '0;
  logic [3:0] Din;
  logic       LoadA, LoadB, Execute;
  logic [2:0] F;
  logic [1:0] R;
  logic [3:0] Aval = '0;
  logic [3:0] Bval = '0;
  logic       busy, chk_fail;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int busy_n, la_n, lb_n, ex_n, fail_n, viol;

  logic [1:0] ops [4];
  int acc, dbl, sa, sb, se, ovl, idx, tot_fail;
  logic prev_rdy;

  logic [7:0] err_255;

  logic unused_ok;

  always #5 Clk = ~Clk;

  logic_proc_cmd_driver dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_f(cmd_f), .cmd_r(cmd_r),
    .Din(Din), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute), .F(F), .R(R),
    .Aval(Aval), .Bval(Bval), .busy(busy), .chk_fail(chk_fail), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command at a negedge and profiles the busy window that follows
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data,
                        input logic [2:0] f, input logic [1:0] r);
    int guard;
    bit seen_idle;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_f = f; cmd_r = r;
    @(negedge Clk);
    cmd_valid = 1'b0;
    busy_n = 0; la_n = 0; lb_n = 0; ex_n = 0; fail_n = 0; viol = 0;
    seen_idle = 1'b0; guard = 0;
    while (busy && guard < 100) begin
      busy_n++;
      if (LoadA) la_n++;
      if (LoadB) lb_n++;
      if (Execute) ex_n++;
      if (chk_fail) fail_n++;
      if ((int'(LoadA) + int'(LoadB) + int'(Execute)) > 1) viol++;
      if ((LoadA || LoadB || Execute) && seen_idle) viol++;
      if (!(LoadA || LoadB || Execute)) seen_idle = 1'b1;
      if ((LoadA || LoadB) && Din !== data[3:0]) viol++;
      if (!(LoadA || LoadB) && Din !== 4'h0) viol++;
      if (Execute && (F !== f || R !== r)) viol++;
      if (cmd_ready) viol++;
      guard++;
      @(negedge Clk);
    end
    if (guard >= 100) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    ops[0] = 2'b00; ops[1] = 2'b10; ops[2] = 2'b11; ops[3] = 2'b01;
    unused_ok = 1'b0;

    repeat (2) @(negedge Clk);
    chk("reset_flags", {31'd0, cmd_ready}, 32'd1);
    chk("reset_outs", {26'd0, busy, LoadA, LoadB, Execute, chk_fail, 1'b0}, 32'd0);
    chk("reset_data", {15'd0, Din, F, R, err_count}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // 1: LOAD_A, LOAD_B, EXEC, CHECK all passing
    do_cmd(2'b00, 8'h0B, 3'b000, 2'b00);
    chk("t1_loada_w", la_n, 2);
    chk("t1_loada_busy", busy_n, 4);
    chk("t1_loada_other", lb_n + ex_n + viol, 0);
    do_cmd(2'b01, 8'h02, 3'b000, 2'b00);
    chk("t1_loadb_w", lb_n, 2);
    chk("t1_loadb_other", la_n + ex_n + viol, 0);
    do_cmd(2'b10, 8'h00, 3'b010, 2'b10);
    chk("t1_exec_w", ex_n, 8);
    chk("t1_exec_busy", busy_n, 10);
    chk("t1_exec_viol", viol + la_n + lb_n, 0);
    Aval = 4'h9; Bval = 4'h2;
    do_cmd(2'b11, 8'h92, 3'b000, 2'b00);
    chk("t1_check_busy", busy_n, 1);
    chk("t1_check_fail", fail_n, 0);
    chk("t1_check_strobes", la_n + lb_n + ex_n + viol, 0);
    chk("t1_err", err_count, 0);
    chk("t1_f_retained", {F, R}, {3'b010, 2'b10});

    // 2: more EXEC/CHECK pairs
    do_cmd(2'b10, 8'h00, 3'b110, 2'b01);
    chk("t2_exec1", {ex_n[7:0], viol[7:0]}, {8'd8, 8'd0});
    Aval = 4'h9; Bval = 4'h4;
    do_cmd(2'b11, 8'h94, 3'b000, 2'b00);
    chk("t2_check1_fail", fail_n, 0);
    chk("t2_fr_after", {F, R}, {3'b110, 2'b01});
    do_cmd(2'b10, 8'h00, 3'b110, 2'b11);
    chk("t2_exec2", {ex_n[7:0], viol[7:0]}, {8'd8, 8'd0});
    Aval = 4'h4; Bval = 4'h9;
    do_cmd(2'b11, 8'h49, 3'b000, 2'b00);
    chk("t2_check2_fail", fail_n, 0);
    chk("t2_err", err_count, 0);

    // 3: failing CHECK
    Aval = 4'h9; Bval = 4'h2;
    do_cmd(2'b11, 8'h00, 3'b000, 2'b00);
    chk("t3_fail_pulse", fail_n, 1);
    chk("t3_busy", busy_n, 1);
    chk("t3_err", err_count, 1);
    chk("t3_fail_low", {31'd0, chk_fail}, 0);

    // 4: cmd_valid held high with changing ops
    acc = 0; dbl = 0; sa = 0; sb = 0; se = 0; ovl = 0; idx = 0; prev_rdy = 1'b0;
    cmd_data = 8'h92; cmd_f = 3'b011; cmd_r = 2'b01; cmd_op = ops[0];
    cmd_valid = 1'b1;
    for (int c = 0; c < 23; c++) begin
      if (cmd_ready) begin
        acc++;
        if (prev_rdy) dbl++;
      end
      if (cmd_ready && (LoadA || LoadB || Execute)) ovl++;
      if ((int'(LoadA) + int'(LoadB) + int'(Execute)) > 1) ovl++;
      prev_rdy = cmd_ready;
      if (LoadA) sa++;
      if (LoadB) sb++;
      if (Execute) se++;
      @(negedge Clk);
      if (prev_rdy && idx < 3) begin
        idx++;
        cmd_op = ops[idx];
      end
    end
    chk("t4_ready_end", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b0;
    chk("t4_accepts", acc, 4);
    chk("t4_ready_single", dbl, 0);
    chk("t4_widths", {sa[7:0], sb[7:0], se[7:0]}, {8'd2, 8'd2, 8'd8});
    chk("t4_overlap", ovl, 0);
    chk("t4_err", err_count, 1);
    @(negedge Clk);

    // 5: Reset in the fourth Execute cycle
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_f = 3'b101; cmd_r = 2'b11;
    @(negedge Clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("t5_exec_on", {29'd0, Execute, F}, {29'd1, 3'b101});
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("t5_after_reset", {22'd0, Execute, F, R, cmd_ready, busy, err_count}, {22'd0, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, 8'd0});
    se = 0;
    for (int c = 0; c < 12; c++) begin
      if (LoadA || LoadB || Execute || !cmd_ready) se++;
      @(negedge Clk);
    end
    chk("t5_dropped", se, 0);

    // 6: 256 failing CHECKs saturate the error counter
    Aval = 4'h9; Bval = 4'h2;
    tot_fail = 0; err_255 = '0;
    for (int k = 0; k < 256; k++) begin
      do_cmd(2'b11, 8'h00, 3'b000, 2'b00);
      tot_fail += fail_n;
      if (k == 254) err_255 = err_count;
    end
    chk("t6_err_255", err_255, 8'hFF);
    chk("t6_err_sat", err_count, 8'hFF);
    chk("t6_last_pulse", fail_n, 1);
    chk("t6_pulses", tot_fail, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
